dmac_nch_datapath: RTL and testbench
====================================

Name: dmac_nch_datapath

Overview:
- Parametrised N-channel DMAC front end, the next-generation main datapath.
- Arbitrates peripheral DMA requests and fetches each winner's 4-word descriptor over the AHB master port (single reads).
- Launches the shared transfer engine, muxes engine or fetch signals onto the master port, and raises per-channel sticky interrupts with error status.

Parameters:
- NUM_CH, 4, number of request channels (2..16); CH_W = $clog2(NUM_CH)
- ADDR_W, 32, AHB address width
- DATA_W, 32, AHB data width (32 or 64); strobe width DATA_W/8
- PERI_STRIDE, 32'h1000_0000, descriptor base of channel c = c*PERI_STRIDE
- CFG_OFFSET, 32'h0000_00A0, descriptor offset within base; words at +0,+4,+8,+C = SAddr, DAddr, Size, Ctrl

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- DmacReq  in  NUM_CH  level request per channel
- irq_clr  in  NUM_CH  one-cycle clear of irq/err bit c
- HReady  in  1  AHB ready
- M_HResp  in  2  AHB response; 2'b01 = ERROR
- MRData  in  DATA_W  AHB read data
- MAddress  out  ADDR_W  AHB address
- MTrans  out  2  AHB HTRANS
- MWrite  out  1  AHB HWRITE
- MBurst_Size  out  3  AHB HBURST
- MWData  out  DATA_W  AHB write data
- MWStrb  out  DATA_W/8  write strobes
- eng_start  out  1  one-cycle engine launch
- eng_saddr, eng_daddr, eng_size  out  32 each  latched descriptor words
- eng_burst  out  5  decoded beats
- eng_hsize  out  2  Ctrl[5:4]
- eng_done, eng_err  in  1 each  engine completion / abort
- eng_MAddress, eng_MTrans, eng_MWrite, eng_MBurst_Size, eng_MWData, eng_MWStrb  in  same widths as M*  engine master signals
- irq  out  NUM_CH  sticky completion interrupt
- err  out  NUM_CH  sticky error flag
- busy  out  1  state != IDLE
- active_ch  out  CH_W  granted channel

Behaviour:
- Reset (sync): state IDLE, all outputs 0, irq/err 0, rr pointer 0, descriptor registers 0; reset mid-transfer abandons the transfer with no irq.
- Eligible channel: DmacReq[c]=1 and irq[c]=0 and err[c]=0 (pending status masks re-grant).
- IDLE: if any eligible channel, grant round-robin starting at rr pointer; latch active_ch; word index k=0; -> FA.
- FA (address phase): MTrans=2'b10, MAddress=active_ch*PERI_STRIDE+CFG_OFFSET+4k, MWrite=0, MBurst_Size=0, MWStrb=0; HReady=1 -> FD, else hold.
- FD (data phase): MTrans=2'b00.
  - Hold while HReady=0.
  - On HReady=1 with M_HResp=2'b01 -> ERR.
  - Otherwise capture MRData[31:0] into word k; k<3 -> FA with k+1; k=3 -> START.
- START: if Size==0 -> DONE (no engine launch); else eng_start=1 for exactly one cycle -> XFER.
- XFER: M* outputs = eng_M* passthrough. eng_err=1 -> ERR (err wins if eng_err and eng_done are simultaneous); eng_done=1 -> DONE.
- DONE: irq[active_ch]<=1; rr pointer <= active_ch+1 (wraps NUM_CH-1 -> 0); -> IDLE.
- ERR: err[active_ch]<=1, irq[active_ch]<=1, rr pointer updated as in DONE; -> IDLE.
- irq_clr[c] clears irq[c] and err[c] the next cycle; a set in the same cycle wins.
- eng_burst decode of Ctrl[3:0]: 0->1, 1->4, 2->8, 3->16, other->1. eng_* descriptor outputs are stable from START until the next fetch.
- Outside FA/FD/XFER: MTrans=0, MAddress=0, MWData=0, MWStrb=0, MWrite=0.
- Minimum latency, grant to eng_start: 9 cycles with HReady=1 (4 x FA/FD + START).

Optional Feature:
- Macro DMAC_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index wins; rr pointer removed.
- Undefined: round-robin as above.

Test Plan:
- NUM_CH=4, DmacReq=4'b0100, fetch returns 0x100/0x200/0x40/0x01, HReady=1 -> reads at 0x2000_00A0..AC; eng_start at cycle 9; eng_burst=4; eng_daddr=0x200; after eng_done, irq=4'b0100.
- DmacReq=4'b1111 held, engine finishes each transfer, irq_clr pulsed after each -> grant order 0,1,2,3,0. With DMAC_FIXED_PRIO_EN, order 0,0,0.
- HReady=0 for 3 cycles in FD of word 2 -> MTrans stays 0, data captured when HReady rises, no skipped word.
- M_HResp=2'b01 on word 1 -> err[c]=1, irq[c]=1, no eng_start, busy=0 next cycle.
- Size word = 0 -> no eng_start, irq set directly from START; eng_err and eng_done asserted together in XFER -> err=1.
- rst asserted during XFER -> next cycle all outputs 0, irq=0; request still high re-granted after release.

Source files
------------

// File: rtl/dmac_nch_datapath.sv
// N-channel DMA front end: request arbitration, 4-word descriptor fetch over AHB,
// engine launch/passthrough and sticky per-channel status. Define DMAC_FIXED_PRIO_EN for lowest-index priority.
module dmac_nch_datapath #(
    parameter int          NUM_CH      = 4,
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] PERI_STRIDE = 32'h1000_0000,
    parameter logic [31:0] CFG_OFFSET  = 32'h0000_00A0,
    localparam int         CH_W        = $clog2(NUM_CH),
    localparam int         STRB_W      = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   DmacReq,
    input  logic [NUM_CH-1:0]   irq_clr,
    input  logic                HReady,
    input  logic [1:0]          M_HResp,
    input  logic [DATA_W-1:0]   MRData,
    output logic [ADDR_W-1:0]   MAddress,
    output logic [1:0]          MTrans,
    output logic                MWrite,
    output logic [2:0]          MBurst_Size,
    output logic [DATA_W-1:0]   MWData,
    output logic [STRB_W-1:0]   MWStrb,
    output logic                eng_start,
    output logic [31:0]         eng_saddr,
    output logic [31:0]         eng_daddr,
    output logic [31:0]         eng_size,
    output logic [4:0]          eng_burst,
    output logic [1:0]          eng_hsize,
    input  logic                eng_done,
    input  logic                eng_err,
    input  logic [ADDR_W-1:0]   eng_MAddress,
    input  logic [1:0]          eng_MTrans,
    input  logic                eng_MWrite,
    input  logic [2:0]          eng_MBurst_Size,
    input  logic [DATA_W-1:0]   eng_MWData,
    input  logic [STRB_W-1:0]   eng_MWStrb,
    output logic [NUM_CH-1:0]   irq,
    output logic [NUM_CH-1:0]   err,
    output logic                busy,
    output logic [CH_W-1:0]     active_ch
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FA    = 3'd1;
    localparam logic [2:0] ST_FD    = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_XFER  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    logic [2:0]         state_r;
    logic [1:0]         word_r;
    logic [CH_W-1:0]    active_ch_r;
    logic [31:0]        saddr_r;
    logic [31:0]        daddr_r;
    logic [31:0]        size_r;
    logic [4:0]         burst_r;
    logic [1:0]         hsize_r;
    logic [NUM_CH-1:0]  irq_r;
    logic [NUM_CH-1:0]  err_r;
    logic [NUM_CH-1:0]  elig_s;
    logic [NUM_CH-1:0]  ch_onehot_s;
    logic [NUM_CH-1:0]  irq_set_s;
    logic [NUM_CH-1:0]  err_set_s;
    logic [CH_W-1:0]    grant_s;
    logic [CH_W-1:0]    next_ptr_s;
    logic               any_elig_s;
    logic [ADDR_W-1:0]  fetch_addr_s;
`ifndef DMAC_FIXED_PRIO_EN
    logic [CH_W-1:0]    rr_r;
`endif

    function automatic logic [4:0] burst_decode(input logic [3:0] code);
        logic [4:0] beats;
        case (code)
            4'd0:    beats = 5'd1;
            4'd1:    beats = 5'd4;
            4'd2:    beats = 5'd8;
            4'd3:    beats = 5'd16;
            default: beats = 5'd1;
        endcase
        return beats;
    endfunction

    // First eligible channel scanning upward from ptr, wrapping at NUM_CH.
    function automatic logic [CH_W-1:0] pick_from(input logic [NUM_CH-1:0] elig,
                                                  input logic [CH_W-1:0]   ptr);
        logic [CH_W:0]   idx;
        logic [CH_W-1:0] win;
        logic            found;
        win   = {CH_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end
            if (!found && elig[idx[CH_W-1:0]]) begin
                win   = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Pending status masks a channel from being granted again.
    assign elig_s      = DmacReq & ~irq_r & ~err_r;
    assign any_elig_s  = |elig_s;
    assign ch_onehot_s = NUM_CH'(1'b1) << active_ch_r;
    assign next_ptr_s  = (active_ch_r == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : active_ch_r + CH_W'(1'b1);
`ifdef DMAC_FIXED_PRIO_EN
    assign grant_s     = pick_from(elig_s, {CH_W{1'b0}});
`else
    assign grant_s     = pick_from(elig_s, rr_r);
`endif
    assign fetch_addr_s = ADDR_W'(active_ch_r) * ADDR_W'(PERI_STRIDE) + ADDR_W'(CFG_OFFSET)
                        + ADDR_W'({word_r, 2'b00});

    // Status set terms raised on the way back to IDLE.
    always_comb begin
        irq_set_s = {NUM_CH{1'b0}};
        err_set_s = {NUM_CH{1'b0}};
        if (state_r == ST_DONE) begin
            irq_set_s = ch_onehot_s;
        end else if (state_r == ST_ERR) begin
            irq_set_s = ch_onehot_s;
            err_set_s = ch_onehot_s;
        end else begin
            irq_set_s = {NUM_CH{1'b0}};
        end
    end

    // Control FSM, descriptor capture and sticky status; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            word_r      <= 2'b00;
            active_ch_r <= {CH_W{1'b0}};
            saddr_r     <= 32'h0;
            daddr_r     <= 32'h0;
            size_r      <= 32'h0;
            burst_r     <= 5'd0;
            hsize_r     <= 2'b00;
            irq_r       <= {NUM_CH{1'b0}};
            err_r       <= {NUM_CH{1'b0}};
`ifndef DMAC_FIXED_PRIO_EN
            rr_r        <= {CH_W{1'b0}};
`endif
        end else begin
            irq_r <= (irq_r & ~irq_clr) | irq_set_s;
            err_r <= (err_r & ~irq_clr) | err_set_s;
            case (state_r)
                ST_IDLE: begin
                    if (any_elig_s) begin
                        active_ch_r <= grant_s;
                        word_r      <= 2'b00;
                        state_r     <= ST_FA;
                    end
                end
                ST_FA: begin
                    if (HReady) begin
                        state_r <= ST_FD;
                    end
                end
                ST_FD: begin
                    if (HReady) begin
                        if (M_HResp == HRESP_ERROR) begin
                            state_r <= ST_ERR;
                        end else begin
                            case (word_r)
                                2'd0:    saddr_r <= MRData[31:0];
                                2'd1:    daddr_r <= MRData[31:0];
                                2'd2:    size_r  <= MRData[31:0];
                                default: begin
                                    burst_r <= burst_decode(MRData[3:0]);
                                    hsize_r <= MRData[5:4];
                                end
                            endcase
                            if (word_r == 2'd3) begin
                                state_r <= ST_START;
                            end else begin
                                word_r  <= word_r + 2'd1;
                                state_r <= ST_FA;
                            end
                        end
                    end
                end
                ST_START: begin
                    state_r <= (size_r == 32'h0) ? ST_DONE : ST_XFER;
                end
                ST_XFER: begin
                    if (eng_err) begin
                        state_r <= ST_ERR;
                    end else if (eng_done) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_r <= ST_IDLE;
`ifndef DMAC_FIXED_PRIO_EN
                    rr_r    <= next_ptr_s;
`endif
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Master port mux: fetch drives it in FA/FD, the engine in XFER, idle otherwise.
    always_comb begin
        MAddress    = {ADDR_W{1'b0}};
        MTrans      = HTRANS_IDLE;
        MWrite      = 1'b0;
        MBurst_Size = 3'b000;
        MWData      = {DATA_W{1'b0}};
        MWStrb      = {STRB_W{1'b0}};
        case (state_r)
            ST_FA: begin
                MTrans   = HTRANS_NONSEQ;
                MAddress = fetch_addr_s;
            end
            ST_FD: begin
                MAddress = fetch_addr_s;
            end
            ST_XFER: begin
                MAddress    = eng_MAddress;
                MTrans      = eng_MTrans;
                MWrite      = eng_MWrite;
                MBurst_Size = eng_MBurst_Size;
                MWData      = eng_MWData;
                MWStrb      = eng_MWStrb;
            end
            default: MTrans = HTRANS_IDLE;
        endcase
    end

    assign eng_start = (state_r == ST_START) && (size_r != 32'h0);
    assign eng_saddr = saddr_r;
    assign eng_daddr = daddr_r;
    assign eng_size  = size_r;
    assign eng_burst = burst_r;
    assign eng_hsize = hsize_r;
    assign irq       = irq_r;
    assign err       = err_r;
    assign busy      = (state_r != ST_IDLE);
    assign active_ch = active_ch_r;

endmodule

// File: tb/tb_dmac_nch_datapath.sv
// Directed/randomized bench for dmac_nch_datapath with a channel-level reference model.
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_dmac_nch_datapath;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  DmacReq, irq_clr;
    logic        HReady;
    logic [1:0]  M_HResp;
    logic [31:0] MRData;
    logic [31:0] MAddress;
    logic [1:0]  MTrans;
    logic        MWrite;
    logic [2:0]  MBurst_Size;
    logic [31:0] MWData;
    logic [3:0]  MWStrb;
    logic        eng_start;
    logic [31:0] eng_saddr, eng_daddr, eng_size;
    logic [4:0]  eng_burst;
    logic [1:0]  eng_hsize;
    logic        eng_done, eng_err;
    logic [31:0] eng_MAddress;
    logic [1:0]  eng_MTrans;
    logic        eng_MWrite;
    logic [2:0]  eng_MBurst_Size;
    logic [31:0] eng_MWData;
    logic [3:0]  eng_MWStrb;
    logic [3:0]  irq, err;
    logic        busy;
    logic [1:0]  active_ch;

    dmac_nch_datapath dut (
        .clk(clk), .rst(rst), .DmacReq(DmacReq), .irq_clr(irq_clr),
        .HReady(HReady), .M_HResp(M_HResp), .MRData(MRData),
        .MAddress(MAddress), .MTrans(MTrans), .MWrite(MWrite), .MBurst_Size(MBurst_Size),
        .MWData(MWData), .MWStrb(MWStrb),
        .eng_start(eng_start), .eng_saddr(eng_saddr), .eng_daddr(eng_daddr), .eng_size(eng_size),
        .eng_burst(eng_burst), .eng_hsize(eng_hsize), .eng_done(eng_done), .eng_err(eng_err),
        .eng_MAddress(eng_MAddress), .eng_MTrans(eng_MTrans), .eng_MWrite(eng_MWrite),
        .eng_MBurst_Size(eng_MBurst_Size), .eng_MWData(eng_MWData), .eng_MWStrb(eng_MWStrb),
        .irq(irq), .err(err), .busy(busy), .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          starts = 0;
    int          cyc = 0;
    logic [3:0]  irq_m, err_m;
    int          ptr_m;
    logic [31:0] desc [4];
    int          ch, g, s0, t0;
    bit          ab;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (eng_start === 1'b1) starts++;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec rule: eligible = requesting with no pending status; scan from pointer (or from 0).
    function automatic int model_grant(input logic [3:0] req);
        logic [3:0] e;
        int c;
        e = req & ~irq_m & ~err_m;
        for (int i = 0; i < N; i++) begin
`ifdef DMAC_FIXED_PRIO_EN
            c = i;
`else
            c = (ptr_m + i) % N;
`endif
            if (((e >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    function automatic logic [4:0] burst_of(input logic [31:0] ctl);
        case (ctl[3:0])
            4'd0:    return 5'd1;
            4'd1:    return 5'd4;
            4'd2:    return 5'd8;
            4'd3:    return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [31:0] exp_addr(input int c, input int k);
        return 32'(c) * 32'h1000_0000 + 32'h0000_00A0 + 32'(4 * k);
    endfunction

    task automatic rand_desc;
        desc[0] = $urandom;
        desc[1] = $urandom;
        desc[2] = 32'($urandom_range(1, 4096));
        desc[3] = $urandom;
    endtask

    task automatic wait_busy;
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            step;
            n++;
        end
        if (busy !== 1'b1) `CHK("wait_busy_timeout", busy, 1'b1);
    endtask

    // Serve the four descriptor reads; optional 3-cycle stall or ERROR response on one word.
    task automatic fetch(input int c, input int stall_word, input int err_word, output bit aborted);
        aborted = 1'b0;
        wait_busy;
        `CHK("grant", active_ch, c);
        for (int k = 0; k < 4; k++) begin
            `CHK("fa_trans", MTrans, 2'b10);
            `CHK("fa_addr", MAddress, exp_addr(c, k));
            `CHK("fa_write", MWrite, 1'b0);
            MRData  = desc[k];
            HReady  = 1'b1;
            M_HResp = (k == err_word) ? 2'b01 : 2'b00;
            step;
            `CHK("fd_trans", MTrans, 2'b00);
            if (k == stall_word) begin
                HReady = 1'b0;
                MRData = ~desc[k];
                for (int s = 0; s < 3; s++) begin
                    step;
                    `CHK("stall_trans", MTrans, 2'b00);
                    `CHK("stall_busy", busy, 1'b1);
                end
                HReady = 1'b1;
                MRData = desc[k];
            end
            step;
            M_HResp = 2'b00;
            if (k == err_word) begin
                aborted = 1'b1;
                break;
            end
        end
    endtask

    // From START: launch check, engine passthrough, completion, then status check in IDLE.
    task automatic finish_xfer(input int c, input bit both);
        int nd;
        if (desc[2] == 32'h0) begin
            `CHK("size0_start", eng_start, 1'b0);
            step;
            `CHK("size0_no_start", eng_start, 1'b0);
            step;
        end else begin
            `CHK("eng_start", eng_start, 1'b1);
            `CHK("eng_saddr", eng_saddr, desc[0]);
            `CHK("eng_daddr", eng_daddr, desc[1]);
            `CHK("eng_size", eng_size, desc[2]);
            `CHK("eng_burst", eng_burst, burst_of(desc[3]));
            `CHK("eng_hsize", eng_hsize, desc[3][5:4]);
            step;
            `CHK("start_once", eng_start, 1'b0);
            nd = $urandom_range(1, 3);
            for (int d = 0; d < nd; d++) begin
                eng_MAddress    = $urandom;
                eng_MTrans      = 2'($urandom);
                eng_MWrite      = 1'($urandom);
                eng_MBurst_Size = 3'($urandom);
                eng_MWData      = $urandom;
                eng_MWStrb      = 4'($urandom);
                #1;
                `CHK("pt_addr", MAddress, eng_MAddress);
                `CHK("pt_trans", MTrans, eng_MTrans);
                `CHK("pt_write", MWrite, eng_MWrite);
                `CHK("pt_burst", MBurst_Size, eng_MBurst_Size);
                `CHK("pt_wdata", MWData, eng_MWData);
                `CHK("pt_strb", MWStrb, eng_MWStrb);
                step;
            end
            eng_done = 1'b1;
            eng_err  = both;
            step;
            eng_done = 1'b0;
            eng_err  = 1'b0;
            step;
        end
        irq_m[c] = 1'b1;
        if (both) err_m[c] = 1'b1;
        ptr_m = (c + 1) % N;
        `CHK("irq", irq, irq_m);
        `CHK("err", err, err_m);
        `CHK("idle_busy", busy, 1'b0);
        `CHK("idle_trans", MTrans, 2'b00);
        `CHK("idle_addr", MAddress, 32'h0);
        `CHK("idle_wdata", MWData, 32'h0);
    endtask

    task automatic clear(input int c);
        irq_clr = 4'(1 << c);
        step;
        irq_clr = 4'b0;
        irq_m[c] = 1'b0;
        err_m[c] = 1'b0;
        `CHK("irq_clr_irq", irq, irq_m);
        `CHK("irq_clr_err", err, err_m);
    endtask

    initial begin
        rst = 1'b1; DmacReq = 4'b0; irq_clr = 4'b0; HReady = 1'b1; M_HResp = 2'b00; MRData = 32'h0;
        eng_done = 1'b0; eng_err = 1'b0; eng_MAddress = 32'h0; eng_MTrans = 2'b00; eng_MWrite = 1'b0;
        eng_MBurst_Size = 3'b0; eng_MWData = 32'h0; eng_MWStrb = 4'b0;
        irq_m = 4'b0; err_m = 4'b0; ptr_m = 0;
        step; step;
        checks++;
        if (busy !== 1'b0) begin failures++; $error("FAIL rst_busy observed=%0h expected=0", busy); end
        checks++;
        if (irq !== 4'b0000) begin failures++; $error("FAIL rst_irq observed=%0h expected=0", irq); end
        checks++;
        if (err !== 4'b0000) begin failures++; $error("FAIL rst_err observed=%0h expected=0", err); end
        checks++;
        if (MTrans !== 2'b00) begin failures++; $error("FAIL rst_trans observed=%0h expected=0", MTrans); end
        checks++;
        if (MAddress !== 32'h0) begin failures++; $error("FAIL rst_addr observed=%0h expected=0", MAddress); end
        checks++;
        if (eng_start !== 1'b0) begin failures++; $error("FAIL rst_start observed=%0h expected=0", eng_start); end
        checks++;
        if (eng_saddr !== 32'h0) begin failures++; $error("FAIL rst_saddr observed=%0h expected=0", eng_saddr); end
        checks++;
        if (eng_burst !== 5'd0) begin failures++; $error("FAIL rst_burst observed=%0h expected=0", eng_burst); end
        checks++;
        if (active_ch !== 2'd0) begin failures++; $error("FAIL rst_active observed=%0h expected=0", active_ch); end
        rst = 1'b0;

        // All channels requesting: grant order follows the arbitration rule.
        for (int t = 0; t < 5; t++) begin
            DmacReq = 4'hF;
            g = model_grant(4'hF);
            rand_desc;
            fetch(g, -1, -1, ab);
            finish_xfer(g, 1'b0);
            DmacReq = 4'h0;
            clear(g);
        end

        // Directed channel 2 descriptor, latency to eng_start.
        DmacReq = 4'b0100;
        desc[0] = 32'h100; desc[1] = 32'h200; desc[2] = 32'h40; desc[3] = 32'h01;
        t0 = cyc;
        fetch(2, -1, -1, ab);
        `CHK("latency", cyc - t0, 9);
        finish_xfer(2, 1'b0);
        `CHK("irq_ch2", irq, 4'b0100);
        DmacReq = 4'h0;
        clear(2);

        // HReady stall in the data phase of word 2.
        ch = $urandom_range(0, 3);
        DmacReq = 4'(1 << ch);
        rand_desc;
        fetch(ch, 2, -1, ab);
        finish_xfer(ch, 1'b0);
        DmacReq = 4'h0;
        clear(ch);

        // ERROR response on word 1.
        ch = $urandom_range(0, 3);
        DmacReq = 4'(1 << ch);
        rand_desc;
        s0 = starts;
        fetch(ch, -1, 1, ab);
        `CHK("aborted", ab, 1'b1);
        step;
        irq_m[ch] = 1'b1; err_m[ch] = 1'b1; ptr_m = (ch + 1) % N;
        `CHK("hresp_err", err, err_m);
        `CHK("hresp_irq", irq, irq_m);
        `CHK("hresp_busy", busy, 1'b0);
        `CHK("hresp_nostart", starts, s0);
        DmacReq = 4'h0;
        clear(ch);

        // Zero-size descriptor completes without launching the engine.
        ch = $urandom_range(0, 3);
        DmacReq = 4'(1 << ch);
        rand_desc;
        desc[2] = 32'h0;
        s0 = starts;
        fetch(ch, -1, -1, ab);
        finish_xfer(ch, 1'b0);
        `CHK("size0_nostart", starts, s0);
        DmacReq = 4'h0;
        clear(ch);

        // eng_err and eng_done together: error wins; status left pending.
        DmacReq = 4'b1000;
        rand_desc;
        fetch(3, -1, -1, ab);
        finish_xfer(3, 1'b1);
        DmacReq = 4'h0;

        // Reset during XFER abandons the transfer; request re-granted afterwards.
        DmacReq = 4'b0010;
        rand_desc;
        fetch(1, -1, -1, ab);
        step;
        eng_MTrans = 2'b10; eng_MAddress = 32'h1234_5678; eng_MWData = 32'hCAFE_0001;
        #1;
        `CHK("xfer_pt_trans", MTrans, 2'b10);
        rst = 1'b1;
        step;
        `CHK("rst2_busy", busy, 1'b0);
        `CHK("rst2_trans", MTrans, 2'b00);
        `CHK("rst2_addr", MAddress, 32'h0);
        `CHK("rst2_wdata", MWData, 32'h0);
        `CHK("rst2_irq", irq, 4'b0);
        `CHK("rst2_err", err, 4'b0);
        `CHK("rst2_saddr", eng_saddr, 32'h0);
        `CHK("rst2_active", active_ch, 2'd0);
        rst = 1'b0;
        eng_MTrans = 2'b00; eng_MAddress = 32'h0; eng_MWData = 32'h0;
        irq_m = 4'b0; err_m = 4'b0; ptr_m = 0;
        rand_desc;
        fetch(1, -1, -1, ab);
        finish_xfer(1, 1'b0);
        DmacReq = 4'h0;
        clear(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
